// File: rtl/cal_pkg.sv
// Shared widths, FSM encoding and the bin-magnitude helper for the peak-gain calibrator.
package cal_pkg;

    localparam int DATA_W    = 24;
    localparam int MAG_W     = 25;
    localparam int BIN_W     = 11;
    localparam int DIV_ITERS = 24;

    typedef enum logic [1:0] {
        ST_ACC  = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } cal_state_t;

    // L1 magnitude; negating -2^23 yields 0x800000, which read as unsigned is exactly 2^23.
    function automatic logic [MAG_W-1:0] cal_mag(input logic [DATA_W-1:0] re,
                                                 input logic [DATA_W-1:0] im);
        logic [DATA_W-1:0] a_re;
        logic [DATA_W-1:0] a_im;
        a_re = re[DATA_W-1] ? -re : re;
        a_im = im[DATA_W-1] ? -im : im;
        return {1'b0, a_re} + {1'b0, a_im};
    endfunction

endpackage

// File: rtl/cal_div.sv
// Restoring divider: quotient = floor((mag_y << FRAC_BITS) / mag_x), one bit per cycle.
module cal_div
    import cal_pkg::*;
#(
    parameter int FRAC_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [MAG_W-1:0]     i_mag_x,
    input  logic [MAG_W-1:0]     i_mag_y,
    output logic                 o_done,
    output logic                 o_sat,
    output logic [DIV_ITERS-1:0] o_quot
);

    localparam int DVD_W = MAG_W + FRAC_BITS;
    localparam int CNT_W = $clog2(DIV_ITERS + 1);

    logic [DVD_W-1:0]     w_dvd;
    logic [DVD_W-1:0]     w_mx_sh;
    logic [MAG_W-1:0]     w_hi;
    logic [DIV_ITERS-1:0] w_lo;
    logic                 w_sat;
    logic [MAG_W:0]       w_trial;
    logic                 w_ge;

    logic [MAG_W-1:0]     r_dvs;
    logic [MAG_W-1:0]     r_rem;
    logic [DIV_ITERS-1:0] r_q;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_done;
    logic                 r_sat;

    assign w_dvd   = DVD_W'(i_mag_y) << FRAC_BITS;
    assign w_mx_sh = DVD_W'(i_mag_x) << FRAC_BITS;
    assign w_hi    = MAG_W'(w_dvd >> DIV_ITERS);
    assign w_lo    = w_dvd[DIV_ITERS-1:0];
    // The last term also flags any quotient that would not fit in DIV_ITERS bits.
    assign w_sat   = (i_mag_x == '0) || (DVD_W'(i_mag_y) >= w_mx_sh) || (w_hi >= i_mag_x);

    // r_q starts as the low dividend bits and fills with quotient bits from the right.
    assign w_trial = {r_rem, r_q[DIV_ITERS-1]};
    assign w_ge    = w_trial >= {1'b0, r_dvs};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dvs  <= '0;
            r_rem  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_sat  <= 1'b0;
        end else if (i_start) begin
            r_dvs  <= i_mag_x;
            r_rem  <= w_hi;
            r_q    <= w_lo;
            r_sat  <= w_sat;
            r_cnt  <= CNT_W'(DIV_ITERS);
            r_done <= 1'b0;
        end else if (r_cnt != '0) begin
            r_rem  <= MAG_W'(w_ge ? (w_trial - {1'b0, r_dvs}) : w_trial);
            r_q    <= {r_q[DIV_ITERS-2:0], w_ge};
            r_cnt  <= r_cnt - 1'b1;
            r_done <= (r_cnt == CNT_W'(1));
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done = r_done;
    assign o_sat  = r_sat;
    assign o_quot = r_q;

endmodule

// File: rtl/cal_peak_gain.sv
// Finds the reference-channel FFT peak per frame and reports |Y|/|X| at that bin.
module cal_peak_gain
    import cal_pkg::*;
#(
    parameter int FRAME_LEN = 2048,
    parameter int FRAC_BITS = 12,
    parameter int SKIP_DC   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] x_re,
    input  logic [DATA_W-1:0] x_im,
    input  logic [DATA_W-1:0] y_re,
    input  logic [DATA_W-1:0] y_im,
    input  logic              fft_out_valid,
    output logic [DATA_W-1:0] gain,
    output logic [BIN_W-1:0]  peak_bin,
    output logic              calvalid
);

    cal_state_t r_state;
    cal_state_t w_state_nxt;

    logic [BIN_W-1:0]  r_bin;
    logic [MAG_W-1:0]  r_pk_mx;
    logic [MAG_W-1:0]  r_pk_my;
    logic [BIN_W-1:0]  r_pk_bin;
    logic [BIN_W-1:0]  r_hold_bin;
    logic [DATA_W-1:0] r_gain;
    logic [BIN_W-1:0]  r_peak_bin;
    logic              r_calvalid;

    logic [MAG_W-1:0]  w_mag_x;
    logic [MAG_W-1:0]  w_mag_y;
    logic              w_last;
    logic              w_close;
    logic              w_take;
    logic [MAG_W-1:0]  w_fin_mx;
    logic [MAG_W-1:0]  w_fin_my;
    logic [BIN_W-1:0]  w_fin_bin;
    logic              w_publish;
    logic              w_div_done;
    logic              w_div_sat;
    logic [DATA_W-1:0] w_div_quot;

    assign w_mag_x = cal_mag(x_re, x_im);
    assign w_mag_y = cal_mag(y_re, y_im);
    assign w_last  = (r_bin == BIN_W'(FRAME_LEN - 1));
    assign w_close = fft_out_valid && w_last;
    // Strict compare keeps the earliest bin on ties.
    assign w_take  = fft_out_valid && ((SKIP_DC == 0) || (r_bin != '0)) && (w_mag_x > r_pk_mx);

    // The closing sample may itself be the peak, so the divider sees the post-sample view.
    assign w_fin_mx  = w_take ? w_mag_x : r_pk_mx;
    assign w_fin_my  = w_take ? w_mag_y : r_pk_my;
    assign w_fin_bin = w_take ? r_bin   : r_pk_bin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin      <= '0;
            r_pk_mx    <= '0;
            r_pk_my    <= '0;
            r_pk_bin   <= '0;
            r_hold_bin <= '0;
        end else if (fft_out_valid) begin
            if (w_last) begin
                r_bin      <= '0;
                r_pk_mx    <= '0;
                r_pk_my    <= '0;
                r_pk_bin   <= '0;
                r_hold_bin <= w_fin_bin;
            end else begin
                r_bin <= r_bin + 1'b1;
                if (w_take) begin
                    r_pk_mx  <= w_mag_x;
                    r_pk_my  <= w_mag_y;
                    r_pk_bin <= r_bin;
                end
            end
        end
    end

    cal_div #(
        .FRAC_BITS (FRAC_BITS)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_close),
        .i_mag_x (w_fin_mx),
        .i_mag_y (w_fin_my),
        .o_done  (w_div_done),
        .o_sat   (w_div_sat),
        .o_quot  (w_div_quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_ACC;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_publish   = 1'b0;
        case (r_state)
            ST_ACC:  w_state_nxt = ST_ACC;
            ST_DIV:  if (w_div_done) w_state_nxt = ST_DONE;
            ST_DONE: begin
                w_state_nxt = ST_ACC;
                w_publish   = 1'b1;
            end
            default: w_state_nxt = ST_ACC;
        endcase
        // A new frame close restarts the divider and drops any pending result.
        if (w_close) begin
            w_state_nxt = ST_DIV;
            w_publish   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gain     <= '0;
            r_peak_bin <= '0;
            r_calvalid <= 1'b0;
        end else begin
            r_calvalid <= w_publish;
            if (w_publish) begin
                r_gain     <= w_div_sat ? '1 : w_div_quot;
                r_peak_bin <= r_hold_bin;
            end
        end
    end

    assign gain     = r_gain;
    assign peak_bin = r_peak_bin;
    assign calvalid = r_calvalid;

endmodule

// File: tb/tb_cal_peak_gain.sv
// Directed bench for cal_peak_gain: latency, gaps, saturation, ties, back-to-back frames, resets.
module tb_cal_peak_gain;

    localparam int FL  = 2048;
    localparam int LAT = 27;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [23:0] x_re, x_im, y_re, y_im;
    logic               fft_out_valid;
    logic [23:0]        gain;
    logic [10:0]        peak_bin;
    logic               calvalid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int close_cyc;

    int          p_cyc[$];
    logic [23:0] p_gain[$];
    logic [10:0] p_bin[$];

    logic signed [23:0] fx_re[FL];
    logic signed [23:0] fx_im[FL];
    logic signed [23:0] fy_re[FL];
    logic signed [23:0] fy_im[FL];

    cal_peak_gain dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .x_re          (x_re),
        .x_im          (x_im),
        .y_re          (y_re),
        .y_im          (y_im),
        .fft_out_valid (fft_out_valid),
        .gain          (gain),
        .peak_bin      (peak_bin),
        .calvalid      (calvalid)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One negedge: outputs are sampled here, away from the rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (calvalid === 1'b1) begin
            p_cyc.push_back(cyc);
            p_gain.push_back(gain);
            p_bin.push_back(peak_bin);
        end
    endtask

    task automatic drive_idle();
        fft_out_valid = 1'b0;
        x_re = '0; x_im = '0; y_re = '0; y_im = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            drive_idle();
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < FL; i++) begin
            fx_re[i] = '0; fx_im[i] = '0; fy_re[i] = '0; fy_im[i] = '0;
        end
    endtask

    task automatic set_bin(input int b, input int xr, input int xi, input int yr, input int yi);
        fx_re[b] = 24'(xr); fx_im[b] = 24'(xi);
        fy_re[b] = 24'(yr); fy_im[b] = 24'(yi);
    endtask

    // Gaps carry large junk data with valid low; it must be ignored.
    task automatic send_frame(input int n_bins, input int gap_every, input int gap_len);
        for (int b = 0; b < n_bins; b++) begin
            if (gap_every > 0 && b > 0 && (b % gap_every) == 0) begin
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    fft_out_valid = 1'b0;
                    x_re = 24'sd9999; x_im = 24'sd9999; y_re = 24'sd77; y_im = 24'sd77;
                end
            end
            tick();
            x_re = fx_re[b]; x_im = fx_im[b]; y_re = fy_re[b]; y_im = fy_im[b];
            fft_out_valid = 1'b1;
            if (b == FL - 1) close_cyc = cyc;
        end
    endtask

    task automatic clear_pulses();
        p_cyc.delete();
        p_gain.delete();
        p_bin.delete();
    endtask

    task automatic expect_one(input string tag, input int exp_cyc,
                              input logic [23:0] eg, input logic [10:0] eb);
        check({tag, " pulses"}, p_cyc.size(), 1);
        if (p_cyc.size() > 0) begin
            check({tag, " cycle"}, p_cyc[0], exp_cyc);
            check({tag, " gain"},  p_gain[0], eg);
            check({tag, " bin"},   p_bin[0], eb);
        end
        check({tag, " gain held"}, gain, eg);
        check({tag, " bin held"},  peak_bin, eb);
        check({tag, " calvalid low"}, calvalid, 0);
        clear_pulses();
    endtask

    initial begin
        int cp;
        int cq;

        rst_n = 1'b0;
        drive_idle();
        clear_frame();
        idle(3);
        check("reset gain", gain, 0);
        check("reset bin", peak_bin, 0);
        check("reset calvalid", calvalid, 0);
        tick();
        rst_n = 1'b1;
        idle(2);
        clear_pulses();

        // Unity ratio at bin 5.
        clear_frame();
        set_bin(5, 1000, 0, 500, -500);
        send_frame(FL, 0, 0);
        cp = close_cyc;
        idle(40);
        expect_one("basic", cp + LAT, 24'h001000, 11'd5);

        // Same frame with 3-cycle gaps every 100 bins.
        send_frame(FL, 100, 3);
        cp = close_cyc;
        idle(40);
        expect_one("gaps", cp + LAT, 24'h001000, 11'd5);

        // All-zero reference saturates.
        clear_frame();
        set_bin(3, 0, 0, 100, 100);
        send_frame(FL, 0, 0);
        cp = close_cyc;
        idle(40);
        expect_one("zero x", cp + LAT, 24'hFFFFFF, 11'd0);

        // Full-scale negative Y against unit X.
        clear_frame();
        set_bin(9, 1, 0, -8388608, -8388608);
        send_frame(FL, 0, 0);
        cp = close_cyc;
        idle(40);
        expect_one("fullscale y", cp + LAT, 24'hFFFFFF, 11'd9);

        // Equal peaks at 7 and 300; larger DC bin skipped. 300*4096/2000 = 614.
        clear_frame();
        set_bin(0, 5000, 0, 77, 0);
        set_bin(7, 2000, 0, 300, 0);
        set_bin(300, 0, -2000, 999, 0);
        send_frame(FL, 0, 0);
        cp = close_cyc;
        idle(40);
        expect_one("tie dc", cp + LAT, 24'h000266, 11'd7);

        // Just below the saturation threshold: 4095*4096/1.
        clear_frame();
        set_bin(20, 1, 0, 4095, 0);
        send_frame(FL, 0, 0);
        cp = close_cyc;
        idle(40);
        expect_one("below sat", cp + LAT, 24'hFFF000, 11'd20);

        // Exactly at the threshold: mag_y = mag_x << 12.
        clear_frame();
        set_bin(20, -1, 0, 0, -4096);
        send_frame(FL, 0, 0);
        cp = close_cyc;
        idle(40);
        expect_one("at sat", cp + LAT, 24'hFFFFFF, 11'd20);

        // Back-to-back: peak on the closing bin (3*4096/7), then |(-3,-4)|=7 vs 10 (40960/7).
        clear_frame();
        set_bin(2047, 7, 0, 3, 0);
        send_frame(FL, 0, 0);
        cp = close_cyc;
        clear_frame();
        set_bin(100, -3, -4, 10, 0);
        send_frame(FL, 0, 0);
        cq = close_cyc;
        idle(40);
        check("b2b pulses", p_cyc.size(), 2);
        if (p_cyc.size() == 2) begin
            check("b2b first cycle", p_cyc[0], cp + LAT);
            check("b2b first gain", p_gain[0], 24'h0006DB);
            check("b2b first bin", p_bin[0], 11'h7FF);
            check("b2b second cycle", p_cyc[1], cq + LAT);
            check("b2b spacing", p_cyc[1] - p_cyc[0], FL);
            check("b2b second gain", p_gain[1], 24'h0016DB);
            check("b2b second bin", p_bin[1], 11'd100);
        end
        clear_pulses();

        // Reset mid-frame after bin 1000; the partial frame has a dominant bin at 500.
        clear_frame();
        set_bin(5, 1000, 0, 500, -500);
        set_bin(500, 30000, 0, 1, 0);
        send_frame(1001, 0, 0);
        tick();
        rst_n = 1'b0;
        drive_idle();
        #1;
        check("midframe rst gain", gain, 0);
        check("midframe rst bin", peak_bin, 0);
        check("midframe rst calvalid", calvalid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        idle(2);
        clear_frame();
        set_bin(9, 2000, 0, 1000, 0);
        send_frame(FL, 0, 0);
        cp = close_cyc;
        idle(40);
        expect_one("after frame rst", cp + LAT, 24'h000800, 11'd9);

        // Reset while the divider is running: result must never appear.
        send_frame(FL, 0, 0);
        idle(10);
        rst_n = 1'b0;
        #1;
        check("div rst gain", gain, 0);
        check("div rst bin", peak_bin, 0);
        tick();
        tick();
        rst_n = 1'b1;
        idle(40);
        check("div rst pulses", p_cyc.size(), 0);
        check("div rst gain held", gain, 0);
        clear_pulses();
        clear_frame();
        set_bin(100, -3, -4, 10, 0);
        send_frame(FL, 0, 0);
        cp = close_cyc;
        idle(40);
        expect_one("after div rst", cp + LAT, 24'h0016DB, 11'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cal_peak_gain.md
CAL_PEAK_GAIN -- requirements
Module: cal_peak_gain

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 2048: valid samples per frame.
REQ-002 SHALL have parameter FRAC_BITS, default 12: fractional bits of gain.
REQ-003 SHALL have parameter SKIP_DC, default 1: when 1, bin 0 is excluded from peak search.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports x_re, x_im, input, 24 each: reference-channel FFT bin, signed two's complement.
REQ-007 SHALL have ports y_re, y_im, input, 24 each: measured-channel FFT bin, signed two's complement.
REQ-008 SHALL have port fft_out_valid, input, 1: sample qualifier; one bin per cycle when high.
REQ-009 SHALL have port gain, output, 24: unsigned Q(24-FRAC_BITS).FRAC_BITS ratio |Y|/|X| at the X peak bin.
REQ-010 SHALL have port peak_bin, output, 11: index of the X peak bin of the last completed frame.
REQ-011 SHALL have port calvalid, output, 1: one-cycle pulse when gain and peak_bin update.

Function
REQ-012 SHALL accept a sample only on edges where fft_out_valid=1; gaps of any length mid-frame SHALL NOT advance the bin counter or end the frame.
REQ-013 SHALL compute per-sample magnitude as |re|+|im|, 25-bit unsigned; |-2^23| = 2^23 exactly, with no wrap.
REQ-014 SHALL count bins 0..FRAME_LEN-1; the sample with bin FRAME_LEN-1 SHALL close the frame, and the counter SHALL wrap to 0.
REQ-015 SHALL track the maximum X magnitude with strict greater-than, so the lowest-index bin wins ties; the Y magnitude and bin index are captured on the same sample.
REQ-016 SHALL initialise the peak to zero magnitude, bin 0, at each frame start; an all-zero X frame yields mag_x=0.
REQ-017 SHALL use states ACC, DIV, DONE: ACC->DIV on the frame-closing sample; DIV->DONE after 24 quotient iterations; DONE->ACC after one cycle.
REQ-018 SHALL hand the peak values to the divider at frame close, so accumulation of the next frame continues in ACC-independent registers with no lost samples.
REQ-019 SHALL saturate gain to 24'hFFFFFF when mag_x=0 or mag_y >= mag_x<<FRAC_BITS; otherwise gain = floor((mag_y<<FRAC_BITS)/mag_x).
REQ-020 SHALL have fixed latency regardless of the saturation path: if the closing sample is accepted on edge N, calvalid is high only in the cycle after edge N+26.
REQ-021 SHALL update gain and peak_bin on the same edge that raises calvalid, and hold them until the next calvalid.
REQ-022 SHALL restart the divider with new operands if a frame closes while DIV is active (FRAME_LEN<27 only); the earlier result SHALL be discarded.

Reset
REQ-023 SHALL on rst_n=0 immediately clear gain=0, peak_bin=0, calvalid=0, the bin counter, the peak registers, and the divider, and enter ACC.
REQ-024 SHALL discard any partial frame or in-flight division on reset mid-operation; the first sample after release is bin 0.

Structure
REQ-025 SHALL take data width 24, magnitude width 25, bin width 11, and the state encoding from shared package cal_pkg.
REQ-026 SHALL place the 24-iteration restoring divider, with start/done handshake, in sub-module cal_div.

Verification
REQ-027 Frame of 2048 valid bins, X=(1000,0) at bin 5 and elsewhere 0, Y=(500,-500) at bin 5 -> calvalid 26 cycles after the last bin; gain=24'h001000; peak_bin=5.
REQ-028 Same frame with fft_out_valid gaps of 3 cycles every 100 bins -> identical gain and peak_bin; calvalid timed from the 2048th accepted sample.
REQ-029 X all zero -> gain=24'hFFFFFF, peak_bin=0; Y=(2^23 each) with X=(1,0) at bin 9 -> gain=24'hFFFFFF, peak_bin=9.
REQ-030 Equal X peaks at bins 7 and 300, plus X=(5000,0) at bin 0 with SKIP_DC=1 -> peak_bin=7.
REQ-031 Two back-to-back frames with no gap -> two calvalid pulses 2048 cycles apart, each with correct values.
REQ-032 rst_n pulsed low at bin 1000 and during DIV -> outputs 0 with no calvalid; the next full frame after release produces the correct result.
